// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction fetch front end.
//
// This block issues one instruction-memory request at a time. Each returned
// word is queued with its PC in a 2-entry FIFO that feeds decode. A redirect
// (branch, jump or trap) flushes the queue and retargets the fetch PC. If a
// request is still in flight when the redirect arrives, its response is
// dropped when it comes back.
//
// Ports
//   clk            : sole clock, rising edge
//   rstn           : asynchronous, active-low reset
//   redirect_valid : redirect request (highest priority)
//   redirect_pc    : redirect target (forced to 4-byte alignment)
//   imem_req       : request to instruction memory
//   imem_addr      : request address (always the fetch PC)
//   imem_gnt       : memory accepts the request this cycle
//   imem_rvalid    : read data valid
//   imem_rdata     : fetched instruction word
//   id_valid       : decode-side instruction valid
//   id_inst        : head instruction (zero when empty)
//   id_pc          : PC of head instruction (zero when empty)
//   id_ready       : decode consumes the head instruction
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,   // nothing outstanding
        ST_WAIT,   // one granted request outstanding
        ST_DROP    // outstanding response must be discarded
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic [63:0] fifo_pc_q   [2];
    logic [63:0] fifo_pc_d   [2];
    logic [31:0] fifo_inst_q [2];
    logic [31:0] fifo_inst_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        push;
    logic        pop;

    // A request is only raised when the FIFO has room for its response. This
    // gating is what makes overflow impossible. Qualifying with rstn keeps
    // the request low for the whole time reset is held.
    assign imem_req  = rstn && (state_q == ST_IDLE) && (count_q != 2'd2) && !redirect_valid;
    assign imem_addr = fetch_pc_q;

    assign id_valid = (count_q != 2'd0);
    assign id_inst  = id_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
    assign id_pc    = id_valid ? fifo_pc_q[rd_ptr_q]   : 64'h0;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (redirect_valid) begin
            // A redirect overrides everything else in this cycle: flush the
            // queue and retarget. An in-flight response still has to be
            // absorbed, unless it is returning in this same cycle.
            fetch_pc_d = {redirect_pc[63:2], 2'b00};
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            case (state_q)
                ST_WAIT, ST_DROP: state_d = imem_rvalid ? ST_IDLE : ST_DROP;
                default:          state_d = ST_IDLE;
            endcase
        end else begin
            pop = id_valid && id_ready;
            case (state_q)
                ST_IDLE: begin
                    if (imem_req && imem_gnt) begin
                        req_pc_d = fetch_pc_q;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        push       = 1'b1;
                        fetch_pc_d = req_pc_q + 64'd4;
                        state_d    = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (push) begin
                fifo_pc_d[wr_ptr_q]   = req_pc_q;
                fifo_inst_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage, one register pair per entry.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    fifo_pc_q[gi]   <= 64'h0;
                    fifo_inst_q[gi] <= 32'h0;
                end else begin
                    fifo_pc_q[gi]   <= fifo_pc_d[gi];
                    fifo_inst_q[gi] <= fifo_inst_d[gi];
                end
            end
        end
    endgenerate

endmodule
